// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use detection.
// Holds one decoded instruction and presents bypassed ALU operands to EX.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [OPW-1:0]  id_alu_op,
    input  logic            id_use_imm,
    input  logic            id_uses_rs2,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [OPW-1:0]  ex_alu_op,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            load_use_hazard
);

    logic            r_valid;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic [REGW-1:0] r_rd;
    logic [OPW-1:0]  r_alu_op;
    logic            r_use_imm;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_reg_write;

    logic            w_hazard;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_mem_rs1;
    logic            w_mem_rs2;
    logic            w_wb_rs1;
    logic            w_wb_rs2;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    assign w_rs1_hit = (r_rd == id_rs1);
    assign w_rs2_hit = id_uses_rs2 && (r_rd == id_rs2);

    assign w_hazard = r_valid && r_mem_read && (r_rd != '0)
                   && id_valid && (w_rs1_hit || w_rs2_hit)
                   && !rst && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_alu_op    <= '0;
            r_use_imm   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_hazard) begin
            // bubble; ID re-presents the same instruction next cycle
            r_valid <= 1'b0;
        end else begin
            r_valid     <= id_valid;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_rs1       <= id_rs1;
            r_rs2       <= id_rs2;
            r_rd        <= id_rd;
            r_alu_op    <= id_alu_op;
            r_use_imm   <= id_use_imm;
            r_mem_read  <= id_mem_read;
            r_mem_write <= id_mem_write;
            r_reg_write <= id_reg_write;
        end
    end

    // MEM is the younger producer, so it is checked first
    assign w_mem_rs1 = mem_reg_write && (mem_rd != '0) && (mem_rd == r_rs1);
    assign w_mem_rs2 = mem_reg_write && (mem_rd != '0) && (mem_rd == r_rs2);
    assign w_wb_rs1  = wb_reg_write && (wb_rd != '0) && (wb_rd == r_rs1);
    assign w_wb_rs2  = wb_reg_write && (wb_rd != '0) && (wb_rd == r_rs2);

    assign w_fwd_rs1 = w_mem_rs1 ? mem_result :
                       w_wb_rs1  ? wb_result  : r_rs1_data;
    assign w_fwd_rs2 = w_mem_rs2 ? mem_result :
                       w_wb_rs2  ? wb_result  : r_rs2_data;

    assign ex_valid        = r_valid;
    assign ex_a            = w_fwd_rs1;
    assign ex_b            = r_use_imm ? r_imm : w_fwd_rs2;
    assign ex_store_data   = w_fwd_rs2;
    assign ex_alu_op       = r_alu_op;
    assign ex_rd           = r_rd;
    assign ex_mem_read     = r_valid && r_mem_read;
    assign ex_mem_write    = r_valid && r_mem_write;
    assign ex_reg_write    = r_valid && r_reg_write;
    assign load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hand sequences
// for reset, load-use, stall and flush.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_use_imm, id_uses_rs2;
    logic        id_mem_read, id_mem_write, id_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write;
    logic        load_use_hazard;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_use_imm(id_use_imm), .id_uses_rs2(id_uses_rs2),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] r1d, r2d, imm;
        logic [4:0]  r1, r2, rd;
        logic [3:0]  op;
        logic        ui, mw, rw;
        logic [4:0]  mrd;
        logic        mrw;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wrw;
        logic [31:0] wres;
        logic        ev;
        logic [31:0] ea, eb, esd;
        logic        emw, erw;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] im,
                          input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [3:0] op,
                          input logic ui, input logic u2,
                          input logic mr, input logic mw,
                          input logic rw);
        id_valid = v; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = im; id_rs1 = s1; id_rs2 = s2; id_rd = d;
        id_alu_op = op; id_use_imm = ui; id_uses_rs2 = u2;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic no_fwd();
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    initial begin
        vt[0] = '{1, 5, 7, 0, 1, 2, 3, 0, 0, 0, 1,
                  0, 0, 0, 0, 0, 0, 1, 5, 7, 7, 0, 1};
        vt[1] = '{1, 5, 7, 'h100, 1, 2, 3, 0, 1, 0, 1,
                  0, 0, 0, 0, 0, 0, 1, 5, 'h100, 7, 0, 1};
        vt[2] = '{1, 1, 7, 0, 4, 2, 3, 0, 0, 0, 1,
                  4, 1, 'hAA, 4, 1, 'hBB, 1, 'hAA, 7, 7, 0, 1};
        vt[3] = '{1, 1, 7, 0, 4, 2, 3, 0, 0, 0, 1,
                  4, 0, 'hAA, 4, 1, 'hBB, 1, 'hBB, 7, 7, 0, 1};
        vt[4] = '{1, 1, 7, 0, 4, 2, 3, 0, 0, 0, 1,
                  0, 1, 'hCC, 4, 0, 'hBB, 1, 1, 7, 7, 0, 1};
        vt[5] = '{1, 5, 2, 0, 1, 7, 0, 'hC, 0, 0, 0,
                  0, 0, 0, 7, 1, 9, 1, 5, 9, 9, 0, 0};
        vt[6] = '{1, 5, 2, 'h44, 1, 7, 0, 'hC, 1, 0, 0,
                  0, 0, 0, 7, 1, 9, 1, 5, 'h44, 9, 0, 0};
        vt[7] = '{0, 5, 7, 0, 1, 2, 3, 0, 0, 1, 1,
                  0, 0, 0, 0, 0, 0, 0, 5, 7, 7, 0, 0};
        vt[8] = '{1, 'h1000, 3, 'h8, 10, 11, 0, 0, 1, 1, 0,
                  11, 1, 'h55, 0, 0, 0, 1, 'h1000, 'h8, 'h55, 1, 0};

        rst = 1; stall = 0; flush = 0;
        no_fwd();
        set_id(1, 1, 2, 3, 1, 2, 3, 4'h5, 0, 1, 0, 1, 1);
        tick();
        tick();
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_regw", 32'(ex_reg_write), 0);
        chk("rst_op", 32'(ex_alu_op), 0);
        chk("rst_hz", 32'(load_use_hazard), 0);
        chk("rst_a", ex_a, 0);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            set_id(vt[i].vld, vt[i].r1d, vt[i].r2d, vt[i].imm,
                   vt[i].r1, vt[i].r2, vt[i].rd, vt[i].op,
                   vt[i].ui, 1'b1, 1'b0, vt[i].mw, vt[i].rw);
            mem_rd = vt[i].mrd; mem_reg_write = vt[i].mrw;
            mem_result = vt[i].mres;
            wb_rd = vt[i].wrd; wb_reg_write = vt[i].wrw;
            wb_result = vt[i].wres;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vt[i].ev));
            chk($sformatf("v%0d_a", i), ex_a, vt[i].ea);
            chk($sformatf("v%0d_b", i), ex_b, vt[i].eb);
            chk($sformatf("v%0d_sd", i), ex_store_data, vt[i].esd);
            chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d_op", i), 32'(ex_alu_op), 32'(vt[i].op));
            chk($sformatf("v%0d_mw", i), 32'(ex_mem_write), 32'(vt[i].emw));
            chk($sformatf("v%0d_rw", i), 32'(ex_reg_write), 32'(vt[i].erw));
            chk($sformatf("v%0d_mr", i), 32'(ex_mem_read), 0);
        end

        // load-use on rs2
        no_fwd();
        set_id(1, 0, 0, 0, 2, 0, 6, 4'h0, 1, 0, 1, 0, 1);
        tick();
        chk("lw_mr", 32'(ex_mem_read), 1);
        set_id(1, 'h21, 'h22, 0, 1, 6, 8, 4'h0, 0, 1, 0, 0, 1);
        #1;
        chk("lu_hz", 32'(load_use_hazard), 1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 0);
        chk("lu_hz_clr", 32'(load_use_hazard), 0);
        tick();
        chk("lu_add_v", 32'(ex_valid), 1);
        chk("lu_add_rd", 32'(ex_rd), 8);
        chk("lu_add_a", ex_a, 'h21);

        // rs2 match ignored when rs2 is unused
        set_id(1, 0, 0, 0, 2, 0, 6, 4'h0, 1, 0, 1, 0, 1);
        tick();
        set_id(1, 'h31, 'h32, 'h4, 1, 6, 9, 4'h0, 1, 0, 0, 0, 1);
        #1;
        chk("nu2_hz", 32'(load_use_hazard), 0);
        tick();
        chk("nu2_v", 32'(ex_valid), 1);
        chk("nu2_rd", 32'(ex_rd), 9);

        // load-use on rs1, flush kills hazard
        set_id(1, 0, 0, 0, 2, 0, 6, 4'h0, 1, 0, 1, 0, 1);
        tick();
        set_id(1, 'h41, 0, 0, 6, 0, 10, 4'h0, 0, 0, 0, 0, 1);
        #1;
        chk("rs1_hz", 32'(load_use_hazard), 1);
        flush = 1;
        #1;
        chk("flush_hz", 32'(load_use_hazard), 0);
        flush = 0;

        // stall for 3 cycles
        set_id(1, 'h11, 'h12, 0, 3, 4, 5, 4'h2, 0, 1, 0, 0, 1);
        tick();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, k + 'h70, k + 'h80, 0, 7, 8, 9 + k, 4'h7,
                   0, 1, 0, 1, 0);
            tick();
            chk($sformatf("st%0d_rd", k), 32'(ex_rd), 5);
            chk($sformatf("st%0d_a", k), ex_a, 'h11);
            chk($sformatf("st%0d_op", k), 32'(ex_alu_op), 2);
            chk($sformatf("st%0d_v", k), 32'(ex_valid), 1);
        end
        wb_rd = 3; wb_reg_write = 1; wb_result = 'hDD;
        #1;
        chk("st_fwd_a", ex_a, 'hDD);
        no_fwd();

        // stall and flush on the same edge
        stall = 0;
        set_id(1, 1, 2, 0, 1, 2, 0, 4'h0, 1, 1, 0, 1, 0);
        tick();
        chk("sf_mw_pre", 32'(ex_mem_write), 1);
        stall = 1; flush = 1;
        tick();
        chk("sf_valid", 32'(ex_valid), 0);
        chk("sf_mw", 32'(ex_mem_write), 0);

        // reset during stall
        stall = 0; flush = 0;
        set_id(1, 1, 2, 0, 1, 2, 4, 4'h1, 0, 1, 0, 0, 1);
        tick();
        chk("rs_pre", 32'(ex_valid), 1);
        stall = 1; rst = 1;
        tick();
        chk("rs_valid", 32'(ex_valid), 0);
        chk("rs_rd", 32'(ex_rd), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
